north_buffer_reader: RTL and testbench
======================================

Name: north_buffer_reader

Overview:
- Read-side sequencer for the weight-stationary North buffer; the buffer is written once and read many times.
- Issues rd_en/rd_addr to the buffer's read port and sweeps addresses 0..COL_X-1 once per pass, for a programmable number of passes (one pass per West row-block).
- Captures rd_dout, which has 1-cycle read latency, into a small skid FIFO and presents it to the systolic array as a valid/ready stream with per-pass framing.

Parameters:
- DATA_WIDTH, 128, width of one buffer word (buffer MODULE_WIDTH).
- COL_X, 16, buffer depth (words per pass).
- ADDR_WIDTH, $clog2(COL_X), read address width.
- PASS_WIDTH, 8, width of the pass-count input.
- SKID_DEPTH, 3, output FIFO entries.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a read job; sampled only in IDLE
- num_passes  input  PASS_WIDTH  number of full sweeps; sampled with start
- busy  output  1  job in progress
- done  output  1  single-cycle completion pulse
- rd_en  output  1  buffer read enable
- rd_addr  output  ADDR_WIDTH  buffer read address
- rd_dout  input  DATA_WIDTH  buffer read data, valid 1 cycle after rd_en
- out_valid  output  1  stream data valid
- out_ready  input  1  downstream accept
- out_data  output  DATA_WIDTH  stream data
- out_last  output  1  beat is address COL_X-1 of a pass
- out_job_last  output  1  final beat of final pass

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, out_job_last=0. FSM=IDLE, FIFO empty, all counters 0.
- Reset mid-job aborts immediately. Any in-flight rd_dout is discarded; done is not pulsed.
- FSM states:
  - IDLE: start=1 and num_passes>0 -> ISSUE. Latch num_passes, set addr=0, pass=0, busy=1.
  - IDLE with start=1 and num_passes=0 -> DONE. No reads are issued.
  - ISSUE: issue reads per the credit rule. After issuing addr COL_X-1 of the final pass -> DRAIN.
  - DRAIN: no new reads. When the FIFO is empty and no read is in flight -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- start while busy is ignored; the latched num_passes is unaffected.
- rd_en and rd_addr are registered outputs.
- Read issue order: addresses 0,1,...,COL_X-1, wrapping to 0 on the next pass. The pass counter increments on that wrap.
- Credit rule: a read may be issued in a cycle only if (FIFO occupancy + reads in flight − pop this cycle) < SKID_DEPTH. The FIFO must never overflow.
- Each FIFO entry stores data plus the last and job_last tags. Tags are computed at issue time from addr and pass.
- out_data, out_last and out_job_last are driven from the FIFO head. They hold stable while out_valid=1 and out_ready=0.
- Pop occurs when out_valid & out_ready.
- Latency: start sampled at cycle T -> rd_en=1, addr=0 at T+1 -> rd_dout at T+2 -> out_valid=1 at T+3.
- Throughput: with out_ready held 1, one beat per cycle is sustained with no bubbles after the first beat.
- Total beats = num_passes × COL_X, exactly once each, in order. There are no duplicates or drops under any out_ready pattern.
- out_last marks every beat with addr=COL_X-1. out_job_last marks only the last beat of the job (this beat also has out_last=1).
- done pulses the cycle after the out_job_last beat is accepted.
- num_passes uses unsigned arithmetic; the maximum is 2^PASS_WIDTH−1.

Test Plan:
- COL_X=4, num_passes=2, out_ready=1, buffer word[i]=i+0xA0:
  - out_data sequence is A0,A1,A2,A3,A0,A1,A2,A3.
  - out_last on beats 4 and 8; out_job_last on beat 8 only.
  - first out_valid at T+3; done one cycle after beat 8; busy 0 afterwards.
- Same job with out_ready randomly 0/1, including held 0 for 10 cycles:
  - identical 8-beat sequence; out_data stable during stalls.
  - FIFO occupancy never exceeds 3; rd_en stops while stalled.
- num_passes=0 with start -> done pulse 2 cycles after start; rd_en never asserted; no out_valid.
- start re-asserted with num_passes=5 mid-job (original num_passes=2) -> ignored; exactly 8 beats; a single done.
- rst_n=0 for one cycle after beat 3 of pass 0 -> next cycle all outputs at reset values and no out_valid afterwards. A new start with num_passes=1 then yields beats A0..A3 from addr 0.
- COL_X=16, num_passes=255, out_ready=1 -> 4080 beats, 255 out_last pulses, no bubbles after the first beat; done asserted exactly once.

Source files
------------

// File: rtl/north_buffer_reader.sv
// north_buffer_reader
// Read-side sequencer for the weight-stationary North buffer. Sweeps read
// addresses 0..COL_X-1 once per pass for num_passes passes. It captures the
// 1-cycle-latency read data into a shift-register skid FIFO and presents it as
// a valid/ready stream. Each beat carries pass-end and job-end tags.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, num_passes job request (sampled only in IDLE)
//   busy, done        job in progress / one-cycle completion pulse
//   rd_en, rd_addr    buffer read port (registered)
//   rd_dout           buffer read data, valid one cycle after rd_en
//   out_valid, out_ready, out_data, out_last, out_job_last  output stream
module north_buffer_reader #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned COL_X      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(COL_X),
  parameter int unsigned PASS_WIDTH = 8,
  parameter int unsigned SKID_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_job_last
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  // Holds FIFO occupancy plus up to two reads in flight.
  localparam int unsigned SUM_W = $clog2(SKID_DEPTH + 3);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COL_X - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  job_last;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_d, done_d, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;

  // Tags travel alongside the read through the 1-cycle buffer latency.
  logic                  iss_last_q, iss_last_d;
  logic                  iss_job_last_q, iss_job_last_d;
  logic                  dv_q, dv_last_q, dv_job_last_q;

  entry_t                mem_q [SKID_DEPTH];
  entry_t                mem_d [SKID_DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_after_pop;
  logic                  out_valid_d;

  logic                  pop, push;
  entry_t                push_entry;
  logic [SUM_W-1:0]      credit_sum;
  logic                  credit_ok;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [PASS_WIDTH-1:0] iss_pass;
  logic [PASS_WIDTH-1:0] iss_total;

  // Head of the shift-register FIFO is a flop, so the stream outputs are too.
  assign out_data     = mem_q[0].data;
  assign out_last     = mem_q[0].last;
  assign out_job_last = mem_q[0].job_last;

  assign pop  = out_valid & out_ready;
  assign push = dv_q;

  // Credit: occupancy + reads in flight - pop must leave room for one more.
  assign credit_sum = SUM_W'(cnt_q) + SUM_W'(rd_en) + SUM_W'(dv_q) - SUM_W'(pop);
  assign credit_ok  = credit_sum < SUM_W'(SKID_DEPTH);

  // Skid FIFO next state: shift on pop, then append behind the survivors.
  always_comb begin
    push_entry.data     = rd_dout;
    push_entry.last     = dv_last_q;
    push_entry.job_last = dv_job_last_q;
    cnt_after_pop       = cnt_q - CNT_W'(pop);
    for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (pop) begin
      for (int unsigned i = 0; i + 1 < SKID_DEPTH; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
      mem_d[SKID_DEPTH-1] = '0;
    end
    if (push) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        if (CNT_W'(i) == cnt_after_pop) begin
          mem_d[i] = push_entry;
        end
      end
    end
    cnt_d       = cnt_after_pop + CNT_W'(push);
    out_valid_d = (cnt_d != '0);
  end

  // Job FSM and read issue.
  always_comb begin
    state_d        = state_q;
    passes_d       = passes_q;
    pass_d         = pass_q;
    addr_d         = addr_q;
    busy_d         = busy;
    done_d         = 1'b0;
    rd_en_d        = 1'b0;
    rd_addr_d      = rd_addr;
    iss_last_d     = 1'b0;
    iss_job_last_d = 1'b0;
    issue          = 1'b0;
    iss_addr       = addr_q;
    iss_pass       = pass_q;
    iss_total      = passes_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (num_passes != '0) begin
            // FIFO is empty in IDLE, so the first read never lacks credit.
            passes_d  = num_passes;
            iss_addr  = '0;
            iss_pass  = '0;
            iss_total = num_passes;
            issue     = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        issue = credit_ok;
      end
      DRAIN: begin
        // The job-last beat is the final one, so accepting it empties the pipe.
        if (pop && out_job_last) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        // Entered with done already high after a drain; a zero-pass job
        // arrives with done low and spends one more cycle raising it.
        if (done) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      rd_en_d        = 1'b1;
      rd_addr_d      = iss_addr;
      busy_d         = 1'b1;
      iss_last_d     = (iss_addr == LAST_ADDR);
      iss_job_last_d = iss_last_d && (iss_pass == iss_total - PASS_WIDTH'(1));
      if (iss_last_d) begin
        addr_d = '0;
        pass_d = iss_pass + PASS_WIDTH'(1);
      end else begin
        addr_d = iss_addr + ADDR_WIDTH'(1);
        pass_d = iss_pass;
      end
      state_d = iss_job_last_d ? DRAIN : ISSUE;
    end
  end

  // State, counters, read pipeline and FIFO storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      passes_q       <= '0;
      pass_q         <= '0;
      addr_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      iss_last_q     <= 1'b0;
      iss_job_last_q <= 1'b0;
      dv_q           <= 1'b0;
      dv_last_q      <= 1'b0;
      dv_job_last_q  <= 1'b0;
      cnt_q          <= '0;
      out_valid      <= 1'b0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      passes_q       <= passes_d;
      pass_q         <= pass_d;
      addr_q         <= addr_d;
      busy           <= busy_d;
      done           <= done_d;
      rd_en          <= rd_en_d;
      rd_addr        <= rd_addr_d;
      iss_last_q     <= iss_last_d;
      iss_job_last_q <= iss_job_last_d;
      dv_q           <= rd_en;
      dv_last_q      <= iss_last_q;
      dv_job_last_q  <= iss_job_last_q;
      cnt_q          <= cnt_d;
      out_valid      <= out_valid_d;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_north_buffer_reader.sv
// Bench for north_buffer_reader: two instances (COL_X=4 and COL_X=16) with a
// behavioural buffer (word[i] = i + 0xA0, 1-cycle read latency). Jobs come
// from a vector table; expected beats are queued at start and popped on accept.
module tb_north_buffer_reader;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start4, start16;
  logic [7:0]    np4, np16;
  logic          ready4, ready16;
  logic          busy4, done4, rden4, ov4, ol4, ojl4;
  logic          busy16, done16, rden16, ov16, ol16, ojl16;
  logic [1:0]    ra4;
  logic [3:0]    ra16;
  logic [DW-1:0] rd4, rd16, od4, od16;

  always #5 clk = ~clk;

  north_buffer_reader #(.DATA_WIDTH(DW), .COL_X(4), .PASS_WIDTH(8), .SKID_DEPTH(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .num_passes(np4), .busy(busy4), .done(done4),
    .rd_en(rden4), .rd_addr(ra4), .rd_dout(rd4), .out_valid(ov4), .out_ready(ready4),
    .out_data(od4), .out_last(ol4), .out_job_last(ojl4));

  north_buffer_reader #(.DATA_WIDTH(DW), .COL_X(16), .PASS_WIDTH(8), .SKID_DEPTH(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .num_passes(np16), .busy(busy16), .done(done16),
    .rd_en(rden16), .rd_addr(ra16), .rd_dout(rd16), .out_valid(ov16), .out_ready(ready16),
    .out_data(od16), .out_last(ol16), .out_job_last(ojl16));

  // Buffer read ports.
  always_ff @(posedge clk) begin
    if (rden4)  rd4  <= DW'(ra4) + DW'('hA0);
    if (rden16) rd16 <= DW'(ra16) + DW'('hA0);
  end

  int            cur_sel;
  logic          c_busy, c_done, c_rden, c_valid, c_last, c_jl;
  int            c_addr;
  logic [DW-1:0] c_data;

  always_comb begin
    if (cur_sel != 0) begin
      c_busy = busy16; c_done = done16; c_rden = rden16; c_addr = 32'(ra16);
      c_valid = ov16; c_data = od16; c_last = ol16; c_jl = ojl16;
    end else begin
      c_busy = busy4; c_done = done4; c_rden = rden4; c_addr = 32'(ra4);
      c_valid = ov4; c_data = od4; c_last = ol4; c_jl = ojl4;
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          jl;
  } beat_t;

  typedef struct {
    int sel;
    int np;
    int mode;       // 0: ready=1, 1: random, 2: random with 10-cycle stall
    bit mid;        // re-assert start with num_passes=5 mid-job
    int exp_beats;
    int exp_lasts;
  } vec_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] np, input logic rdy);
    if (sel == 0) begin
      start4 = st; np4 = np; ready4 = rdy; start16 = 1'b0; ready16 = 1'b1;
    end else begin
      start16 = st; np16 = np; ready16 = rdy; start4 = 1'b0; ready4 = 1'b1;
    end
  endtask

  task automatic run_job(input int j, input vec_t v);
    int col, budget, cyc, issued, acc, max_out, nlast, ndone, done_cyc, jl_acc;
    int first_v, first_acc, last_acc, seq_err, stab_err, rd_at1, busy_at1, addr_at1;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last, prev_jl, rdy, st;
    logic [7:0] npin;
    beat_t e;
    col = (v.sel != 0) ? 16 : 4;
    cur_sel = v.sel;
    exp_q.delete();
    for (int p = 0; p < v.np; p++)
      for (int a = 0; a < col; a++)
        exp_q.push_back({DW'(a + 'hA0), a == col - 1, (p == v.np - 1) && (a == col - 1)});
    budget = v.np * col * 8 + 60;
    issued = 0; acc = 0; max_out = 0; nlast = 0; ndone = 0; done_cyc = -1; jl_acc = -1;
    first_v = -1; first_acc = -1; last_acc = -1; seq_err = 0; stab_err = 0;
    rd_at1 = 0; busy_at1 = 0; addr_at1 = -1; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_jl = 1'b0;
    cyc = 0;
    while (cyc <= budget) begin
      case (v.mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc >= 5 && cyc < 15) ? 1'b0 : 1'($urandom_range(0, 1));
      endcase
      st   = (cyc == 0) || (v.mid && cyc == 6);
      npin = (cyc == 0) ? 8'(v.np) : (v.mid ? 8'd5 : 8'(v.np));
      drive(v.sel, st, npin, rdy);
      if (cyc == 1) begin
        rd_at1 = int'(c_rden); busy_at1 = int'(c_busy); addr_at1 = c_addr;
      end
      if (c_rden) issued++;
      if (issued - acc > max_out) max_out = issued - acc;
      if (c_valid && first_v < 0) first_v = cyc;
      if (prev_stall && (!c_valid || c_data != prev_data || c_last != prev_last || c_jl != prev_jl))
        stab_err++;
      prev_stall = c_valid && !rdy;
      prev_data = c_data; prev_last = c_last; prev_jl = c_jl;
      if (c_valid && rdy) begin
        if (exp_q.size() == 0) begin
          seq_err++;
        end else begin
          e = exp_q.pop_front();
          if (e.data != c_data || e.last != c_last || e.jl != c_jl) seq_err++;
        end
        acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (c_last) nlast++;
        if (c_jl) jl_acc = cyc;
      end
      if (c_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
      cyc++;
    end
    drive(v.sel, 1'b0, 8'd0, 1'b1);
    check($sformatf("job%0d_done_seen", j), longint'(done_cyc >= 0), 1);
    check($sformatf("job%0d_beats", j), acc, v.exp_beats);
    check($sformatf("job%0d_seq_err", j), seq_err, 0);
    check($sformatf("job%0d_leftover", j), exp_q.size(), 0);
    check($sformatf("job%0d_lasts", j), nlast, v.exp_lasts);
    check($sformatf("job%0d_done_count", j), ndone, 1);
    check($sformatf("job%0d_stall_stable", j), stab_err, 0);
    check($sformatf("job%0d_max_outstanding_le3", j), longint'(max_out <= 3), 1);
    check($sformatf("job%0d_busy_after", j), c_busy, 0);
    check($sformatf("job%0d_issued", j), issued, v.exp_beats);
    if (v.np > 0) begin
      check($sformatf("job%0d_rden_at_T1", j), rd_at1, 1);
      check($sformatf("job%0d_addr_at_T1", j), addr_at1, 0);
      check($sformatf("job%0d_busy_at_T1", j), busy_at1, 1);
      check($sformatf("job%0d_first_valid", j), first_v, 3);
      check($sformatf("job%0d_done_cycle", j), done_cyc, jl_acc + 1);
    end else begin
      check($sformatf("job%0d_zero_no_valid", j), first_v, -1);
      check($sformatf("job%0d_zero_done_cycle", j), done_cyc, 2);
    end
    if (v.mode == 0 && v.np > 0)
      check($sformatf("job%0d_no_bubbles", j), last_acc - first_acc, v.exp_beats - 1);
  endtask

  vec_t vecs[$];

  initial begin
    int acc, cyc, quiet_err;
    vecs.push_back('{0,   2, 0, 1'b0,    8,   2});
    vecs.push_back('{0,   2, 1, 1'b0,    8,   2});
    vecs.push_back('{0,   2, 2, 1'b0,    8,   2});
    vecs.push_back('{0,   0, 0, 1'b0,    0,   0});
    vecs.push_back('{0,   2, 1, 1'b1,    8,   2});
    vecs.push_back('{0,   2, 0, 1'b1,    8,   2});
    vecs.push_back('{0,   3, 2, 1'b0,   12,   3});
    vecs.push_back('{1, 255, 0, 1'b0, 4080, 255});
    vecs.push_back('{1,   1, 1, 1'b0,   16,   1});

    cur_sel = 0;
    rst_n = 1'b0;
    start4 = 1'b0; start16 = 1'b0; np4 = '0; np16 = '0; ready4 = 1'b1; ready16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_rd_en", rden4, 0);
    check("rst_rd_addr", ra4, 0);
    check("rst_out_valid", ov4, 0);
    check("rst_out_data_nonzero", longint'(od4 != '0), 0);
    check("rst_out_last", ol4, 0);
    check("rst_out_job_last", ojl4, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_job(i, vecs[i]);

    // Reset mid-job after the third beat of pass 0.
    cur_sel = 0;
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 50) begin
      drive(0, cyc == 0, 8'd2, 1'b1);
      if (c_valid) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_reached_beat3", acc, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_busy", c_busy, 0);
    check("rst_mid_done", c_done, 0);
    check("rst_mid_rd_en", c_rden, 0);
    check("rst_mid_rd_addr", c_addr, 0);
    check("rst_mid_out_valid", c_valid, 0);
    check("rst_mid_out_data_nonzero", longint'(c_data != '0), 0);
    check("rst_mid_out_last", c_last, 0);
    check("rst_mid_out_job_last", c_jl, 0);
    quiet_err = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (c_valid || c_rden || c_done || c_busy) quiet_err++;
    end
    check("rst_mid_quiet_after", quiet_err, 0);
    run_job(100, '{0, 1, 0, 1'b0, 4, 1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
